load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Initiator side of the data-memory port: a load/store controller between the processor's execute/memory stage and the single-port data memory.
- Accepts one word load or store at a time from the core over a valid/ready handshake.
- Checks the byte address, then drives the memory enable, write-enable, word address and write data for exactly one cycle.
- Waits out the memory's fixed read latency and returns load data or a store acknowledge on a registered valid/ready response channel.

Parameters:
- ADDR_W, 10, memory word-address width (depth 2**ADDR_W words)
- DATA_W, 32, data word width
- READ_LATENCY, 1, cycles from the enable-sampling edge to valid mem_rdata; legal 1..3

Ports:
- clk  input  1  system clock
- rst  input  1  reset; synchronous and active-high
- req_valid  input  1  core request valid
- req_ready  output  1  unit can accept a request
- req_write  input  1  1 = store, 0 = load
- req_addr  input  32  byte address
- req_wdata  input  DATA_W  store data
- resp_valid  output  1  response valid
- resp_ready  input  1  core accepts response
- resp_rdata  output  DATA_W  load data; 0 for stores and errors
- resp_err  output  1  request was misaligned or out of range
- mem_en  output  1  memory enable (read strobe)
- mem_we  output  1  memory write enable
- mem_addr  output  ADDR_W  memory word address
- mem_wdata  output  DATA_W  memory write data
- mem_rdata  input  DATA_W  memory read data

Behaviour:
- Reset (rst high at a clk edge):
  - state goes to IDLE; req_ready=0 while rst is high.
  - resp_valid=0, resp_err=0, resp_rdata=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, latency counter=0.
- Word address is req_addr[ADDR_W+1:2].
- Error conditions:
  - req_addr[1:0]!=0, or
  - req_addr[31:ADDR_W+2]!=0.
- States:
  - IDLE: req_ready=1. Handshake on req_valid&&req_ready at edge T.
    - Error: no memory access; go to RESP with resp_err=1 and resp_rdata=0; resp_valid from T+1.
    - Otherwise: latch req_write, word address and wdata; go to ISSUE.
  - ISSUE (cycle T+1): mem_en=1, mem_addr and mem_wdata driven from registers, mem_we=req_write. These are asserted for exactly this one cycle.
    - Store: go to RESP; resp_valid from T+2, resp_rdata=0, resp_err=0.
    - Load: go to WAIT; counter loads READ_LATENCY-1.
  - WAIT: mem_en=0, mem_we=0.
    - When counter==0, capture mem_rdata into resp_rdata and go to RESP.
    - Otherwise decrement the counter.
    - Load response is valid from T+2+READ_LATENCY, i.e. T+3 at default.
  - RESP: resp_valid=1 and resp_rdata/resp_err held stable until resp_ready. On resp_valid&&resp_ready go to IDLE. req_ready=0.
- Outstanding requests and throughput:
  - Only one request may be outstanding.
  - req_ready is 0 in ISSUE, WAIT and RESP; a request presented there is not accepted and must be held by the core.
  - Best-case throughput is one store per 3 cycles (IDLE, ISSUE, RESP) with resp_ready tied high.
- mem_addr and mem_wdata hold their last value outside ISSUE. Only mem_en/mem_we qualify them.
- resp_valid and resp_rdata come from registers; there is no combinational path from mem_rdata to the outputs.
- Reset mid-operation:
  - Any in-flight load is discarded and no response is produced.
  - A store whose ISSUE cycle already completed has been written to memory.
  - rst during the ISSUE cycle forces mem_en/mem_we to 0 from the next edge; the memory sees the strobe only if it sampled before the reset edge.
- resp_ready asserted while resp_valid=0 is ignored.

Decomposition:
- Shared package lsu_pkg:
  - state enum {IDLE, ISSUE, WAIT, RESP}
  - localparams for the address-check field bounds
  - function word_addr(byte_addr)
- One small combinational sub-module is natural: lsu_addr_check (inputs req_addr; outputs word address and error flag), reused later for instruction-fetch range checks.

Test Plan:
- Store then load, default latency: store addr 0x0000_0010, data 0xDEAD_BEEF. mem_en=mem_we=1 with mem_addr=4 for exactly one cycle; resp_valid at T+2, err=0. Then load 0x10: resp_rdata=0xDEAD_BEEF at T+3.
- Misaligned: load 0x0000_0013. mem_en never asserted; resp_valid at T+1 with resp_err=1, resp_rdata=0. Same for out-of-range address 0x0000_1000.
- Backpressure: load completes with resp_ready=0 for 5 cycles. resp_valid and resp_rdata stay stable, req_ready stays 0 and a second req_valid is not accepted. Raise resp_ready: IDLE next cycle, second request accepted.
- READ_LATENCY=3 build: load 0x0000_0FFC (word 1023). Response at T+5 with the stored value; mem_en high only at T+1.
- Reset mid-load: rst pulsed in the WAIT cycle. No resp_valid afterwards; all outputs 0, req_ready=0 while rst is high, 1 the cycle after rst falls.
- Back-to-back with resp_ready tied 1: 4 stores to words 0..3 issue one every 3 cycles. Read-back returns each value in order.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and address-field bounds for the load/store unit
// and the address checker.
package lsu_pkg;

  localparam int BYTE_ADDR_W = 32;
  localparam int WORD_LSB    = 2;  // byte-offset bits within a 32-bit word
  localparam int CNT_W       = 2;  // wide enough for READ_LATENCY-1 up to 2

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } lsu_state_e;

  function automatic logic [BYTE_ADDR_W-1:0] word_addr(input logic [BYTE_ADDR_W-1:0] byte_addr);
    return byte_addr >> WORD_LSB;
  endfunction

endpackage

// File: rtl/lsu_addr_check.sv
// Byte-address to word-address conversion with alignment and range check.
// Purely combinational so it can also be reused for fetch-side checks.
module lsu_addr_check
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic [BYTE_ADDR_W-1:0] i_addr,
  output logic [ADDR_W-1:0]      o_word_addr,
  output logic                   o_err
);

  logic w_misaligned;
  logic w_out_of_range;

  assign o_word_addr    = ADDR_W'(word_addr(i_addr));
  assign w_misaligned   = |i_addr[WORD_LSB-1:0];
  // Any set bit above the word-address field falls outside the memory.
  assign w_out_of_range = |(i_addr >> (ADDR_W + WORD_LSB));
  assign o_err          = w_misaligned | w_out_of_range;

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store controller between the core and a
// fixed-latency single-port data memory.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W       = 10,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic [BYTE_ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0]      req_wdata,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [DATA_W-1:0]      resp_rdata,
  output logic                   resp_err,
  output logic                   mem_en,
  output logic                   mem_we,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [DATA_W-1:0]      mem_wdata,
  input  logic [DATA_W-1:0]      mem_rdata
);

  lsu_state_e        r_state;
  lsu_state_e        w_next_state;
  logic              r_write;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_err;
  logic [CNT_W-1:0]  r_cnt;

  logic [ADDR_W-1:0] w_word_addr;
  logic              w_addr_err;
  logic              w_req_fire;
  logic              w_resp_fire;

  lsu_addr_check #(
    .ADDR_W(ADDR_W)
  ) u_addr_check (
    .i_addr     (req_addr),
    .o_word_addr(w_word_addr),
    .o_err      (w_addr_err)
  );

  // Ready is masked by rst so nothing is accepted during the reset cycle.
  assign req_ready   = (r_state == IDLE) && !rst;
  assign w_req_fire  = req_valid && req_ready;
  assign w_resp_fire = resp_valid && resp_ready;

  // NOTE: assign every always_comb output a default first so no path leaves it unassigned (latch).
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_req_fire) w_next_state = w_addr_err ? RESP : ISSUE;
      ISSUE:   w_next_state = r_write ? RESP : WAIT;
      WAIT:    if (r_cnt == '0) w_next_state = RESP;
      RESP:    if (w_resp_fire) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req_fire) begin
            r_rdata <= '0;
            r_err   <= w_addr_err;
            if (!w_addr_err) begin
              r_write <= req_write;
              r_addr  <= w_word_addr;
              r_wdata <= req_wdata;
            end
          end
        end
        ISSUE: r_cnt <= CNT_W'(READ_LATENCY - 1);
        WAIT: begin
          if (r_cnt == '0) r_rdata <= mem_rdata;
          else             r_cnt   <= r_cnt - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // The strobe exists only while the state register sits in ISSUE.
  assign mem_en     = (r_state == ISSUE);
  assign mem_we     = (r_state == ISSUE) && r_write;
  assign mem_addr   = r_addr;
  assign mem_wdata  = r_wdata;
  assign resp_valid = (r_state == RESP);
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench: a default-latency unit and a READ_LATENCY=3 unit, each
// with its own memory model; sel3 steers stimulus and observation.
module tb_load_store_unit;

  localparam logic [31:0] GARB = 32'hBAD0_BAD0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel3 = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic        resp_ready = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  int          n_total = 0;
  int          n_bad = 0;
  int          cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rr1, rv1, re1, me1, mw1, rr3, rv3, re3, me3, mw3;
  logic [31:0] rd1, wd1, mrd1, rd3, wd3, mrd3;
  logic [9:0]  ma1, ma3;

  load_store_unit #(.ADDR_W(10), .DATA_W(32), .READ_LATENCY(1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid && !sel3), .req_ready(rr1),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rv1), .resp_ready(resp_ready), .resp_rdata(rd1), .resp_err(re1),
    .mem_en(me1), .mem_we(mw1), .mem_addr(ma1), .mem_wdata(wd1), .mem_rdata(mrd1)
  );

  load_store_unit #(.ADDR_W(10), .DATA_W(32), .READ_LATENCY(3)) dut3 (
    .clk(clk), .rst(rst), .req_valid(req_valid && sel3), .req_ready(rr3),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rv3), .resp_ready(resp_ready), .resp_rdata(rd3), .resp_err(re3),
    .mem_en(me3), .mem_we(mw3), .mem_addr(ma3), .mem_wdata(wd3), .mem_rdata(mrd3)
  );

  // Memory models: rdata is valid READ_LATENCY cycles after the enable edge,
  // and garbage otherwise so a mistimed capture is visible.
  logic [31:0] mem1 [1024];
  logic [31:0] mem3 [1024];
  logic [31:0] p3a = GARB, p3b = GARB, p3c = GARB;
  logic [31:0] p1 = GARB;

  always @(posedge clk) begin
    if (me1 && mw1) mem1[ma1] <= wd1;
    p1 <= (me1 && !mw1) ? mem1[ma1] : GARB;
    if (me3 && mw3) mem3[ma3] <= wd3;
    p3a <= (me3 && !mw3) ? mem3[ma3] : GARB;
    p3b <= p3a;
    p3c <= p3b;
  end
  assign mrd1 = p1;
  assign mrd3 = p3c;

  logic        o_rr, o_rv, o_re, o_me, o_mw;
  logic [31:0] o_rd, o_wd;
  logic [9:0]  o_ma;
  assign o_rr = sel3 ? rr3 : rr1;
  assign o_rv = sel3 ? rv3 : rv1;
  assign o_re = sel3 ? re3 : re1;
  assign o_me = sel3 ? me3 : me1;
  assign o_mw = sel3 ? mw3 : mw1;
  assign o_rd = sel3 ? rd3 : rd1;
  assign o_wd = sel3 ? wd3 : wd1;
  assign o_ma = sel3 ? ma3 : ma1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One complete transaction; lat is the cycle (1 = cycle after the
  // accepting edge) in which resp_valid must first appear.
  task automatic do_req(input string tag, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wd, input int lat, input logic exp_err,
                        input logic [31:0] exp_rd);
    int waited = 0;
    while (!o_rr && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check({tag, "/ready"}, 32'(o_rr), 32'd1);
    req_valid  = 1'b1;
    req_write  = wr;
    req_addr   = addr;
    req_wdata  = wd;
    resp_ready = 1'b0;
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
      check({tag, "/en"}, 32'(o_me), 32'(k == 1 && !exp_err));
      check({tag, "/rv"}, 32'(o_rv), 32'(k == lat));
      check({tag, "/rr_busy"}, 32'(o_rr), 32'd0);
      if (k == 1 && !exp_err) begin
        check({tag, "/we"}, 32'(o_mw), 32'(wr));
        check({tag, "/maddr"}, 32'(o_ma), 32'(addr[11:2]));
        if (wr) check({tag, "/mwdata"}, o_wd, wd);
      end
    end
    check({tag, "/rdata"}, o_rd, exp_rd);
    check({tag, "/err"}, 32'(o_re), 32'(exp_err));
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check({tag, "/idle_rv"}, 32'(o_rv), 32'd0);
    check({tag, "/idle_rr"}, 32'(o_rr), 32'd1);
  endtask

  initial begin
    int c_prev;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst/rr", 32'(o_rr), 32'd0);
    check("rst/rv", 32'(o_rv), 32'd0);
    check("rst/err", 32'(o_re), 32'd0);
    check("rst/rdata", o_rd, 32'd0);
    check("rst/en", 32'(o_me), 32'd0);
    check("rst/we", 32'(o_mw), 32'd0);
    check("rst/maddr", 32'(o_ma), 32'd0);
    check("rst/mwdata", o_wd, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst/rr_after", 32'(o_rr), 32'd1);

    // Store then load, default latency
    do_req("st10", 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 2, 1'b0, 32'd0);
    do_req("ld10", 1'b0, 32'h0000_0010, 32'd0, 3, 1'b0, 32'hDEAD_BEEF);

    // Misaligned and out-of-range
    do_req("mis13", 1'b0, 32'h0000_0013, 32'd0, 1, 1'b1, 32'd0);
    do_req("oor1000", 1'b0, 32'h0000_1000, 32'd0, 1, 1'b1, 32'd0);
    do_req("mis_st", 1'b1, 32'h0000_0022, 32'h1111_1111, 1, 1'b1, 32'd0);

    // Backpressure with a second request held by the core
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_0010;
    @(negedge clk);
    check("bp/issue_en", 32'(o_me), 32'd1);
    req_write = 1'b1; req_addr = 32'h0000_0020; req_wdata = 32'h1234_5678;
    @(negedge clk);
    check("bp/wait_rv", 32'(o_rv), 32'd0);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      check("bp/rv", 32'(o_rv), 32'd1);
      check("bp/rdata", o_rd, 32'hDEAD_BEEF);
      check("bp/rr", 32'(o_rr), 32'd0);
      check("bp/en", 32'(o_me), 32'd0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check("bp/idle_rv", 32'(o_rv), 32'd0);
    check("bp/idle_rr", 32'(o_rr), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    check("bp/2nd_en", 32'(o_me), 32'd1);
    check("bp/2nd_we", 32'(o_mw), 32'd1);
    check("bp/2nd_maddr", 32'(o_ma), 32'd8);
    check("bp/2nd_wdata", o_wd, 32'h1234_5678);
    @(negedge clk);
    check("bp/2nd_rv", 32'(o_rv), 32'd1);
    check("bp/2nd_err", 32'(o_re), 32'd0);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    do_req("ld20", 1'b0, 32'h0000_0020, 32'd0, 3, 1'b0, 32'h1234_5678);

    // READ_LATENCY=3 unit, top word
    sel3 = 1'b1;
    @(negedge clk);
    do_req("l3_st", 1'b1, 32'h0000_0FFC, 32'hCAFE_F00D, 2, 1'b0, 32'd0);
    do_req("l3_ld", 1'b0, 32'h0000_0FFC, 32'd0, 5, 1'b0, 32'hCAFE_F00D);
    sel3 = 1'b0;
    @(negedge clk);

    // Reset in the WAIT cycle of a load
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_0010;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("rl/wait_rv", 32'(o_rv), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("rl/rr", 32'(o_rr), 32'd0);
    check("rl/rv", 32'(o_rv), 32'd0);
    check("rl/rdata", o_rd, 32'd0);
    check("rl/en", 32'(o_me), 32'd0);
    check("rl/maddr", 32'(o_ma), 32'd0);
    check("rl/mwdata", o_wd, 32'd0);
    @(negedge clk);
    check("rl/rr_hold", 32'(o_rr), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rl/rr_after", 32'(o_rr), 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rl/no_resp", 32'(o_rv), 32'd0);
    end

    // Back-to-back stores, resp_ready tied high
    resp_ready = 1'b1;
    req_valid = 1'b1; req_write = 1'b1;
    req_addr = 32'd0; req_wdata = 32'hA000_0000;
    c_prev = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("b2b/en", 32'(o_me), 32'd1);
      check("b2b/maddr", 32'(o_ma), 32'(i));
      check("b2b/wdata", o_wd, 32'hA000_0000 + 32'(i));
      if (i > 0) check("b2b/spacing", 32'(cyc - c_prev), 32'd3);
      c_prev = cyc;
      if (i < 3) begin
        req_addr  = 32'(4 * (i + 1));
        req_wdata = 32'hA000_0000 + 32'(i + 1);
      end else begin
        req_valid = 1'b0;
      end
      @(negedge clk);
      check("b2b/rv", 32'(o_rv), 32'd1);
      check("b2b/rr", 32'(o_rr), 32'd0);
      check("b2b/en_resp", 32'(o_me), 32'd0);
      @(negedge clk);
      check("b2b/idle_rr", 32'(o_rr), 32'd1);
    end
    resp_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      do_req("b2b_rd", 1'b0, 32'(4 * i), 32'd0, 3, 1'b0, 32'hA000_0000 + 32'(i));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
